// File: rtl/mem_stage_unit.sv
// mem_stage_unit: pipeline MEM stage.
// Takes the EX/MEM latch and issues the data-memory request. It stalls the pipeline until
// dmem_ready arrives, or until the wait times out. It also owns the MEM/WB register.
//
// Optional feature: define MEM2MEM_FWD_EN to forward load data from MEM/WB to a following store.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   mem_write, mem_read           EX/MEM store / load request (mutually exclusive)
//   wb_in                         {RegWrite, MemtoReg, PCtoReg, Halt}
//   alu_in, st_data_in, pc_in     ALU result / address, store data, PC+2
//   dst_in, src2_in               destination register, store-data source register
//   dmem_req/we/addr/wdata        data-memory request side
//   dmem_rdata, dmem_ready        data-memory response side
//   mem_stall                     hold upstream latches this cycle
//   mem_err                       sticky timeout flag, cleared only by reset
//   wb_out, wb_data_out, dst_out  MEM/WB register
module mem_stage_unit #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  wb_in,
    input  logic [15:0] alu_in,
    input  logic [15:0] st_data_in,
    input  logic [3:0]  dst_in,
    input  logic [3:0]  src2_in,
    input  logic [15:0] pc_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [3:0]  wb_out,
    output logic [15:0] wb_data_out,
    output logic [3:0]  dst_out
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0]       wb_q, wb_d;
    logic [15:0]      data_q, data_d;
    logic [3:0]       dst_q, dst_d;

    logic        access;
    logic        req;
    logic        stall;
    logic        cnt_at_limit;
    logic [15:0] rdata_sel;
    logic [15:0] data_sel;

    assign access       = mem_read | mem_write;
    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req = access;
                if (access && !dmem_ready) begin
                    stall   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                req = 1'b1;
                if (dmem_ready) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_at_limit) begin
                    // Abort: the access completes with zero read data and the error flag is set.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // dmem_ready is only meaningful during a request. An aborted access reads as zero.
    assign rdata_sel = (access && dmem_ready) ? dmem_rdata : 16'h0000;
    assign data_sel  = wb_in[2] ? rdata_sel : (wb_in[1] ? pc_in : alu_in);

    // A stall cycle loads a bubble. Every other cycle completes an instruction into MEM/WB.
    always_comb begin
        wb_d   = 4'h0;
        data_d = 16'h0000;
        dst_d  = 4'h0;
        if (!stall) begin
            wb_d   = wb_in;
            data_d = data_sel;
            dst_d  = dst_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wb_q    <= 4'h0;
            data_q  <= 16'h0000;
            dst_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
            data_q  <= data_d;
            dst_q   <= dst_d;
        end
    end

    // The request side is gated by reset so that an in-flight request drops immediately.
    assign dmem_req  = rst & req;
    assign dmem_we   = rst & mem_write;
    assign mem_stall = rst & stall;
    assign dmem_addr = alu_in;

`ifdef MEM2MEM_FWD_EN
    logic fwd_hit;
    // The store reads a register that the instruction now in MEM/WB is about to write.
    assign fwd_hit    = mem_write & wb_q[3] & (dst_q != 4'h0) & (dst_q == src2_in);
    assign dmem_wdata = fwd_hit ? data_q : st_data_in;
`else
    logic unused_src2;
    assign unused_src2 = ^src2_in;
    assign dmem_wdata  = st_data_in;
`endif

    assign mem_err     = err_q;
    assign wb_out      = wb_q;
    assign wb_data_out = data_q;
    assign dst_out     = dst_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write, mem_read;
    logic [3:0]  wb_in, dst_in, src2_in;
    logic [15:0] alu_in, st_data_in, pc_in;
    logic        dmem_req, dmem_we, dmem_ready, mem_stall, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data_out;
    logic [3:0]  wb_out, dst_out;

    mem_stage_unit #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .wb_in       (wb_in),
        .alu_in      (alu_in),
        .st_data_in  (st_data_in),
        .dst_in      (dst_in),
        .src2_in     (src2_in),
        .pc_in       (pc_in),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ready  (dmem_ready),
        .mem_stall   (mem_stall),
        .mem_err     (mem_err),
        .wb_out      (wb_out),
        .wb_data_out (wb_data_out),
        .dst_out     (dst_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: architectural MEM/WB contents, the error flag, and how many cycles the
    // current request has already been outstanding.
    logic [3:0]  m_wb, m_dst;
    logic [15:0] m_data;
    logic        m_err;
    int          m_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wb = 4'h0; m_dst = 4'h0; m_data = 16'h0; m_err = 1'b0; m_wait = 0;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic [3:0] wb,
                         input logic [15:0] alu, input logic [15:0] st, input logic [3:0] dst,
                         input logic [3:0] src2, input logic [15:0] pc);
        mem_write = mw; mem_read = mr; wb_in = wb; alu_in = alu; st_data_in = st;
        dst_in = dst; src2_in = src2; pc_in = pc;
    endtask

    // Called at a falling edge. Applies the response, checks the request side, clocks once, checks
    // MEM/WB, and returns at the next falling edge.
    task automatic cycle(input logic ready, input logic [15:0] rdata, output logic stalled);
        logic        acc, ok, abort, stall, hit;
        logic [15:0] exp_wd, nd;
        dmem_ready = ready;
        dmem_rdata = rdata;
        #1;
        acc   = mem_read | mem_write;
        ok    = acc & ready;
        abort = acc & !ready & (m_wait == TMO);
        stall = acc & !ready & (m_wait < TMO);
        hit   = 1'b0;
`ifdef MEM2MEM_FWD_EN
        hit = mem_write & m_wb[3] & (m_dst != 4'h0) & (m_dst == src2_in);
`endif
        exp_wd = hit ? m_data : st_data_in;
        check_eq("req", dmem_req, acc | (m_wait > 0));
        check_eq("stall", mem_stall, stall);
        check_eq("we", dmem_we, mem_write);
        check_eq("addr", dmem_addr, alu_in);
        check_eq("wdata", dmem_wdata, exp_wd);
        nd = wb_in[2] ? (ok ? rdata : 16'h0) : (wb_in[1] ? pc_in : alu_in);
        @(posedge clk);
        #1;
        if (stall) begin
            m_wb = 4'h0; m_dst = 4'h0; m_data = 16'h0; m_wait++;
        end else begin
            m_wb = wb_in; m_dst = dst_in; m_data = nd; m_wait = 0;
        end
        if (abort) m_err = 1'b1;
        check_eq("wb_out", wb_out, m_wb);
        check_eq("wb_data", wb_data_out, m_data);
        check_eq("dst_out", dst_out, m_dst);
        check_eq("mem_err", mem_err, m_err);
        @(negedge clk);
        stalled = stall;
    endtask

    initial begin
        logic        st;
        int          n;
        int          kind, lat, c;
        logic [3:0]  d, s2;
        logic        rw, h;
        logic [15:0] rd;

        rst = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 16'h0;
        drive(0, 0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0);
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_wb", wb_out, 0);
        check_eq("rst_data", wb_data_out, 0);
        check_eq("rst_dst", dst_out, 0);
        check_eq("rst_err", mem_err, 0);
        check_eq("rst_req", dmem_req, 0);
        rst = 1'b1;

        // ALU op: one-cycle pass-through.
        drive(0, 0, 4'h8, 16'h1234, 16'h0, 4'd3, 4'd0, 16'h0);
        cycle(1'b0, 16'h0, st);
        check_eq("alu_wb", wb_out, 4'h8);
        check_eq("alu_data", wb_data_out, 16'h1234);
        check_eq("alu_dst", dst_out, 4'd3);
        check_eq("alu_nostall", st, 0);

        // Load with same-cycle ready.
        drive(0, 1, 4'hC, 16'h0040, 16'h0, 4'd5, 4'd0, 16'h0);
        cycle(1'b1, 16'hBEEF, st);
        check_eq("ld0_stall", st, 0);
        check_eq("ld0_data", wb_data_out, 16'hBEEF);

        // Load with ready on the fourth cycle: three stall cycles and three bubbles.
        drive(0, 1, 4'hC, 16'h0042, 16'h0, 4'd6, 4'd0, 16'h0);
        n = 0;
        c = 0;
        do begin
            cycle(c == 3, 16'hBEEF, st);
            if (st) begin
                n++;
                check_eq("ld3_bubble", wb_out, 4'h0);
            end
            c++;
        end while (st && c < 10);
        check_eq("ld3_nstall", n, 3);
        check_eq("ld3_data", wb_data_out, 16'hBEEF);
        check_eq("ld3_dst", dst_out, 4'd6);

        // Store that never gets ready: times out and sets the sticky error.
        drive(1, 0, 4'h0, 16'h0080, 16'h7777, 4'd0, 4'd1, 16'h0);
        n = 0;
        c = 0;
        do begin
            cycle(1'b0, 16'h0, st);
            if (st) n++;
            c++;
        end while (st && c < 40);
        check_eq("tmo_nstall", n, TMO);
        check_eq("tmo_err", mem_err, 1);
        drive(0, 0, 4'h8, 16'h0101, 16'h0, 4'd2, 4'd0, 16'h0);
        cycle(1'b1, 16'h0, st);
        check_eq("tmo_resume", st, 0);
        check_eq("tmo_err_sticky", mem_err, 1);

        // Load r4 = 00AA, then a store that reads r4.
        drive(0, 1, 4'hC, 16'h0010, 16'h0, 4'd4, 4'd0, 16'h0);
        cycle(1'b1, 16'h00AA, st);
        drive(1, 0, 4'h0, 16'h0012, 16'h5555, 4'd0, 4'd4, 16'h0);
        dmem_ready = 1'b1;
        #1;
`ifdef MEM2MEM_FWD_EN
        check_eq("fwd_wdata", dmem_wdata, 16'h00AA);
`else
        check_eq("fwd_wdata", dmem_wdata, 16'h5555);
`endif
        cycle(1'b1, 16'h0, st);

        // Reset while a load is waiting.
        drive(0, 1, 4'hC, 16'h0020, 16'h0, 4'd7, 4'd0, 16'h0);
        cycle(1'b0, 16'h0, st);
        cycle(1'b0, 16'h0, st);
        check_eq("mid_req_before", dmem_req, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_req", dmem_req, 0);
        check_eq("mid_stall", mem_stall, 0);
        check_eq("mid_wb", wb_out, 0);
        check_eq("mid_data", wb_data_out, 0);
        check_eq("mid_dst", dst_out, 0);
        check_eq("mid_err", mem_err, 0);
        @(negedge clk);
        drive(0, 0, 4'h8, 16'h0303, 16'h0, 4'd9, 4'd0, 16'h0);
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 16'h0, st);
        check_eq("post_rst_data", wb_data_out, 16'h0303);

        // Randomized instruction stream.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            d    = 4'($urandom_range(0, 15));
            s2   = ($urandom_range(0, 1) == 1) ? m_dst : 4'($urandom_range(0, 15));
            rw   = 1'($urandom_range(0, 1));
            h    = 1'($urandom_range(0, 1));
            lat  = $urandom_range(0, 9);
            lat  = (lat == 9) ? 99 : (lat % 4);
            rd   = 16'($urandom);
            unique case (kind)
                0: drive(0, 0, {rw, 2'b00, h}, 16'($urandom), 16'($urandom), d, s2, 16'($urandom));
                1: drive(0, 1, {rw, 2'b10, h}, 16'($urandom), 16'($urandom), d, s2, 16'($urandom));
                2: drive(1, 0, {1'b0, 2'b00, h}, 16'($urandom), 16'($urandom), d, s2,
                         16'($urandom));
                default: drive(0, 0, {rw, 2'b01, h}, 16'($urandom), 16'($urandom), d, s2,
                               16'($urandom));
            endcase
            c = 0;
            do begin
                if (kind == 0 || kind == 3) cycle(1'($urandom_range(0, 1)), 16'($urandom), st);
                else cycle(c == lat, rd, st);
                c++;
            end while (st && c < TMO + 4);
            check_eq("txn_bound", st, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
